// File: rtl/bram_stream_fifo.sv
// Ring-buffer FIFO controller in front of a dual-port block RAM with registered read data.
// A two-entry head/skid buffer absorbs the read latency so both streams sustain one byte per cycle.
module bram_stream_fifo #(
  parameter int ADDR_BITS = 11,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ADDR_BITS+1:0] level,
  output logic                 wren,
  output logic [ADDR_BITS-1:0] wraddress,
  output logic [DATA_W-1:0]    data_in,
  output logic                 oen,
  output logic [ADDR_BITS-1:0] rdaddress,
  input  logic [DATA_W-1:0]    data_out
);

  localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(1) << ADDR_BITS;

  logic [ADDR_BITS:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   mem_count, mem_count_d;
  logic                 inflight_q;
  logic [1:0]           occ_q, occ_d;
  logic                 s_ready_q, s_ready_d;
  logic [ADDR_BITS+1:0] level_q, level_d;
  logic [DATA_W-1:0]    head_q, skid_q;
  logic                 push, pop, issue, cap;
  logic [2:0]           pending;

  assign push    = s_valid & s_ready_q;
  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign cap     = inflight_q;

  // Entries that will occupy the buffer once the in-flight read lands, net of this cycle's pop.
  assign pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign mem_count = wr_ptr_q - rd_ptr_q;
  assign issue     = (mem_count != '0) && (pending < 3'd2);

  assign wr_ptr_d    = wr_ptr_q + (ADDR_BITS+1)'(push);
  assign rd_ptr_d    = rd_ptr_q + (ADDR_BITS+1)'(issue);
  assign mem_count_d = wr_ptr_d - rd_ptr_d;
  assign s_ready_d   = (mem_count_d < DEPTH);

  always_comb begin
    occ_d = occ_q;
    case ({pop, cap})
      2'b10:   occ_d = occ_q - 2'd1;
      2'b01:   occ_d = occ_q + 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  assign level_d = {1'b0, mem_count_d} + (ADDR_BITS+2)'(issue) + (ADDR_BITS+2)'(occ_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      s_ready_q  <= 1'b0;
      level_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= issue;
      occ_q      <= occ_d;
      s_ready_q  <= s_ready_d;
      level_q    <= level_d;
    end
  end

  // Head always holds the oldest byte; skid only fills while head is waiting on the consumer.
  always_ff @(posedge clk) begin
    if (cap && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)))
      head_q <= data_out;
    else if (pop && (occ_q == 2'd2))
      head_q <= skid_q;
    if (cap && (((occ_q == 2'd1) && !pop) || ((occ_q == 2'd2) && pop)))
      skid_q <= data_out;
  end

  assign s_ready   = s_ready_q;
  assign m_data    = head_q;
  assign level     = level_q;
  assign wren      = push;
  assign wraddress = wr_ptr_q[ADDR_BITS-1:0];
  assign data_in   = s_data;
  assign oen       = issue;
  assign rdaddress = rd_ptr_q[ADDR_BITS-1:0];

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Bench for bram_stream_fifo: behavioural RAM plus a queue scoreboard tracking held bytes and order.
module tb_bram_stream_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [12:0] level;
  logic        wren;
  logic [10:0] wraddress;
  logic [7:0]  data_in;
  logic        oen;
  logic [10:0] rdaddress;
  logic [7:0]  data_out;

  always #5 clk = ~clk;

  bram_stream_fifo #(.ADDR_BITS(11), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level),
    .wren(wren), .wraddress(wraddress), .data_in(data_in),
    .oen(oen), .rdaddress(rdaddress), .data_out(data_out)
  );

  // Dual-port RAM with registered read output
  logic [7:0] ram [0:2047];
  always @(posedge clk) begin
    if (wren) ram[wraddress] <= data_in;
    if (oen)  data_out <= ram[rdaddress];
  end

  int total = 0;
  int bad   = 0;

  logic [7:0]  q[$];
  int          lvl_exp = 0;
  logic [10:0] wa_exp = '0;
  int          pushes = 0, pops = 0, cycn = 0;
  int          first_push = -1, first_mv = -1, first_pop = -1, last_pop = -1;
  logic        stall_prev = 1'b0;
  logic [7:0]  hold_data = '0;
  logic [7:0]  last_pop_data = '0;
  logic        seen_occ2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, update the reference, return 1 time unit after the rising edge.
  task automatic cyc();
    logic push, pop;
    @(negedge clk);
    push = s_valid & s_ready;
    pop  = m_valid & m_ready;
    chk("level", 32'(level), 32'(lvl_exp));
    chk("wren", 32'(wren), 32'(push));
    if (lvl_exp == 0) chk("oen_empty", 32'(oen), 32'd0);
    if (push) begin
      chk("wraddr", 32'(wraddress), 32'(wa_exp));
      chk("data_in", 32'(data_in), 32'(s_data));
    end
    if (stall_prev) chk("hold", 32'({m_valid, m_data}), 32'({1'b1, hold_data}));
    if (pop) begin
      chk("m_data", 32'(m_data), (q.size() != 0) ? 32'(q[0]) : 32'hDEADBEEF);
      if (q.size() != 0) void'(q.pop_front());
      last_pop_data = m_data;
      if (first_pop < 0) first_pop = cycn;
      last_pop = cycn;
      pops++;
    end
    if (m_valid && first_mv < 0) first_mv = cycn;
    if (push && first_push < 0) first_push = cycn;
    stall_prev = m_valid & !m_ready;
    hold_data  = m_data;
    if (push) begin
      q.push_back(s_data);
      wa_exp++;
      pushes++;
    end
    lvl_exp = lvl_exp + int'(push) - int'(pop);
    if (dut.occ_q == 2'd2) seen_occ2 = 1'b1;
    cycn++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, pbase, n;
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h5A; m_ready = 1'b0;
    #12;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_oen", 32'(oen), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    chk("s_ready_up", 32'(s_ready), 32'd1);

    // Three-byte burst and latency
    s_valid = 1'b1; s_data = 8'h11; cyc();
    s_data = 8'h22; cyc();
    s_data = 8'h33; cyc();
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (8) cyc();
    chk("burst_pushes", 32'(pushes), 32'd3);
    chk("latency", 32'(first_mv - first_push), 32'd3);
    chk("burst_pops", 32'(pops), 32'd3);
    chk("burst_consec", 32'(last_pop - first_pop), 32'd2);
    chk("burst_data_last", 32'(last_pop_data), 32'h33);
    chk("burst_level", 32'(level), 32'd0);

    // Fill to capacity with the consumer stalled
    m_ready = 1'b0; s_valid = 1'b1; base = pushes;
    for (int i = 0; i < 2100; i++) begin
      s_data = 8'(pushes - base);
      cyc();
    end
    chk("full_accepts", 32'(pushes - base), 32'd2050);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_level", 32'(level), 32'd2050);
    s_valid = 1'b0; m_ready = 1'b1; pbase = pops;
    repeat (2060) cyc();
    chk("full_drain", 32'(pops - pbase), 32'd2050);
    chk("full_empty", 32'(level), 32'd0);

    // Long stream across pointer wrap
    s_valid = 1'b1; m_ready = 1'b1; base = pushes; pbase = pops; first_pop = -1; n = 0;
    while ((pushes - base) < 5000 && n < 5200) begin
      s_data = 8'($urandom);
      cyc();
      n++;
    end
    chk("wrap_in_cycles", 32'(n), 32'd5000);
    s_valid = 1'b0;
    repeat (10) cyc();
    chk("wrap_pops", 32'(pops - pbase), 32'd5000);
    chk("wrap_no_gap", 32'(last_pop - first_pop + 1), 32'd5000);

    // Alternating consumer backpressure
    seen_occ2 = 1'b0; base = pushes; pbase = pops; n = 0;
    while ((pops - pbase) < 16 && n < 200) begin
      s_valid = ((pushes - base) < 16);
      s_data  = 8'($urandom);
      m_ready = (n % 2 == 0);
      cyc();
      n++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("bp_pops", 32'(pops - pbase), 32'd16);
    chk("bp_pushes", 32'(pushes - base), 32'd16);
    chk("bp_skid_used", 32'(seen_occ2), 32'd1);
    repeat (3) cyc();

    // Simultaneous push and pop at level 1
    s_valid = 1'b1; s_data = 8'($urandom); cyc();
    s_valid = 1'b0; n = 0;
    while (!m_valid && n < 10) begin cyc(); n++; end
    chk("l1_valid", 32'(m_valid), 32'd1);
    chk("l1_level", 32'(level), 32'd1);
    s_valid = 1'b1; m_ready = 1'b1; s_data = 8'($urandom); cyc();
    s_valid = 1'b0; m_ready = 1'b0;
    chk("l1_level_after", 32'(level), 32'd1);
    repeat (4) cyc();
    chk("l1_level_settled", 32'(level), 32'd1);
    chk("l1_valid_settled", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    repeat (3) cyc();
    chk("l1_drained", 32'(level), 32'd0);

    // Reset in the middle of a burst
    s_valid = 1'b1; m_ready = 1'b1;
    repeat (10) begin s_data = 8'($urandom); cyc(); end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_wren", 32'(wren), 32'd0);
    chk("mid_rst_oen", 32'(oen), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    q.delete(); lvl_exp = 0; wa_exp = '0; stall_prev = 1'b0;
    s_valid = 1'b0; m_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_level", 32'(level), 32'd0);
    s_valid = 1'b1; s_data = 8'hA5; base = pushes; n = 0;
    while (pushes == base && n < 5) begin cyc(); n++; end
    s_valid = 1'b0; m_ready = 1'b1; pbase = pops; n = 0;
    while (pops == pbase && n < 10) begin cyc(); n++; end
    chk("post_rst_pops", 32'(pops - pbase), 32'd1);
    chk("post_rst_first", 32'(last_pop_data), 32'hA5);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
